tff_bank_arbiter: RTL and testbench

//  Shares one WIDTH-bit bank of toggle flip-flops (q <= q ^ mask) among NREQ requesters.

---
 rtl/tff_bank_arbiter.sv | 150 +++++++++++++++
 tb/tb_tff_bank_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/tff_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tff_bank_arbiter
// Description : Round-robin arbiter that shares one WIDTH-bit toggle bank
//               (q <= q ^ mask) among NREQ requesters. One op per grant,
//               with a one-cycle ack, a registered commit and a recover slot.
// Revision    : 1.0 - initial release
// ============================================================================
module tff_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] mask,
  input  logic                  clr,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic                  busy,
  output logic [15:0]           ops
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_APPLY   = 2'd1;
  localparam logic [1:0] S_RECOVER = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win_q, win_d;
  logic [WIDTH-1:0] mask_l_q, mask_l_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [WIDTH-1:0] bank_q, bank_d;
  logic [15:0]      ops_q, ops_d;

  logic             found;
  logic [PW-1:0]    pick;
  logic [PW:0]      idx;
  logic [WIDTH-1:0] sel_mask;
  logic [NREQ-1:0]  gnt;
  logic [PW-1:0]    ptr_next;

  // Round-robin search: first requester at or after ptr, wrapping at NREQ.
  // idx has one spare bit so ptr+k never overflows before the wrap.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(k);
      if (idx >= (PW+1)'(NREQ)) begin
        idx = idx - (PW+1)'(NREQ);
      end
      if (!found && req[idx[PW-1:0]]) begin
        found = 1'b1;
        pick  = idx[PW-1:0];
      end
    end
  end

  // Decode the winner into its mask slice and a one-hot grant vector.
  always_comb begin
    sel_mask = '0;
    gnt      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == PW'(i)) begin
        sel_mask = mask[i*WIDTH +: WIDTH];
        gnt[i]   = found;
      end
    end
  end

  // Requester just served drops to lowest priority on the next search.
  always_comb begin
    if (win_q == PW'(NREQ-1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = win_q + PW'(1);
    end
  end

  // Operation sequencing; clr forces the bank to zero in every state and
  // wins over the commit, but never disturbs the handshake or counters.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    mask_l_d = mask_l_q;
    ack_d    = ack_q;
    ops_d    = ops_q;
    bank_d   = clr ? '0 : bank_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          win_d    = pick;
          mask_l_d = sel_mask;
          ack_d    = gnt;
          state_d  = S_APPLY;
        end else begin
          ack_d = '0;
        end
      end
      S_APPLY: begin
        bank_d  = clr ? '0 : (bank_q ^ mask_l_q);
        ops_d   = ops_q + 16'd1;
        ptr_d   = ptr_next;
        ack_d   = '0;
        state_d = S_RECOVER;
      end
      S_RECOVER: begin
        ack_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        ack_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      mask_l_q <= '0;
      ack_q    <= '0;
      bank_q   <= '0;
      ops_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      mask_l_q <= mask_l_d;
      ack_q    <= ack_d;
      bank_q   <= bank_d;
      ops_q    <= ops_d;
    end
  end

  assign ack  = ack_q;
  assign q    = bank_q;
  assign busy = (state_q != S_IDLE);
  assign ops  = ops_q;

endmodule
`default_nettype wire

// File: tb/tb_tff_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tff_bank_arbiter
// Description : Self-checking bench for tff_bank_arbiter (NREQ=4, WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tff_bank_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] mask;
  logic        clr;
  logic [3:0]  ack;
  logic [7:0]  q;
  logic        busy;
  logic [15:0] ops;

  int vectors;
  int miscompares;

  tff_bank_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .mask (mask),
    .clr  (clr),
    .ack  (ack),
    .q    (q),
    .busy (busy),
    .ops  (ops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: transaction-level view of the bank and its handshake.
  logic [7:0]  m_q;
  logic [15:0] m_ops;
  logic [3:0]  m_ack;
  logic [7:0]  m_mask;
  int          m_ptr;
  int          m_win;
  int          m_phase;   // 0 waiting, 1 op granted, 2 cool-down

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] mask;
    logic        clr;
    logic [3:0]  ack;
    logic [7:0]  q;
    logic        busy;
    logic [15:0] ops;
  } vec_t;

  vec_t tbl[20];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic [3:0] rq, input logic [31:0] mk, input logic c);
    logic got;
    int   j;
    if (r) begin
      m_q = '0; m_ops = '0; m_ack = '0; m_ptr = 0; m_phase = 0; m_win = 0;
    end else if (m_phase == 0) begin
      got   = 1'b0;
      m_ack = '0;
      for (int k = 0; k < 4; k++) begin
        j = (m_ptr + k) % 4;
        if (!got && rq[j]) begin
          got     = 1'b1;
          m_win   = j;
          m_mask  = mk[j*8 +: 8];
          m_ack   = 4'(1 << j);
          m_phase = 1;
        end
      end
      if (c) m_q = '0;
    end else if (m_phase == 1) begin
      m_q     = c ? 8'h00 : (m_q ^ m_mask);
      m_ops   = m_ops + 16'd1;
      m_ptr   = (m_win + 1) % 4;
      m_ack   = '0;
      m_phase = 2;
    end else begin
      m_ack   = '0;
      m_phase = 0;
      if (c) m_q = '0;
    end
  endtask

  // Drive inputs on the falling edge, take the rising edge, compare on the next falling edge.
  task automatic tick(input logic r, input logic [3:0] rq, input logic [31:0] mk, input logic c);
    rst  = r;
    req  = rq;
    mask = mk;
    clr  = c;
    model_step(r, rq, mk, c);
    @(posedge clk);
    @(negedge clk);
    check("ack",  32'(ack),  32'(m_ack));
    check("q",    32'(q),    32'(m_q));
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("ops",  32'(ops),  32'(m_ops));
  endtask

  logic [3:0]  r_req;
  logic [31:0] r_mask;
  logic        r_rst;
  logic        r_clr;
  int          order[4];
  logic [7:0]  qexp[4];

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; req = '0; mask = '0; clr = 1'b0;
    m_q = '0; m_ops = '0; m_ack = '0; m_mask = '0; m_ptr = 0; m_win = 0; m_phase = 0;

    // single toggle twice, then four simultaneous requesters
    tbl[0]  = '{1'b1, 4'b0000, 32'h0000000F, 1'b0, 4'b0000, 8'h00, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, 4'b0001, 32'h0000000F, 1'b0, 4'b0001, 8'h00, 1'b1, 16'd0};
    tbl[2]  = '{1'b0, 4'b0000, 32'h0000000F, 1'b0, 4'b0000, 8'h0F, 1'b1, 16'd1};
    tbl[3]  = '{1'b0, 4'b0000, 32'h0000000F, 1'b0, 4'b0000, 8'h0F, 1'b0, 16'd1};
    tbl[4]  = '{1'b0, 4'b0001, 32'h0000000F, 1'b0, 4'b0001, 8'h0F, 1'b1, 16'd1};
    tbl[5]  = '{1'b0, 4'b0000, 32'h0000000F, 1'b0, 4'b0000, 8'h00, 1'b1, 16'd2};
    tbl[6]  = '{1'b0, 4'b0000, 32'h0000000F, 1'b0, 4'b0000, 8'h00, 1'b0, 16'd2};
    tbl[7]  = '{1'b1, 4'b0000, 32'h08040201, 1'b0, 4'b0000, 8'h00, 1'b0, 16'd0};
    tbl[8]  = '{1'b0, 4'b1111, 32'h08040201, 1'b0, 4'b0001, 8'h00, 1'b1, 16'd0};
    tbl[9]  = '{1'b0, 4'b1110, 32'h08040201, 1'b0, 4'b0000, 8'h01, 1'b1, 16'd1};
    tbl[10] = '{1'b0, 4'b1110, 32'h08040201, 1'b0, 4'b0000, 8'h01, 1'b0, 16'd1};
    tbl[11] = '{1'b0, 4'b1110, 32'h08040201, 1'b0, 4'b0010, 8'h01, 1'b1, 16'd1};
    tbl[12] = '{1'b0, 4'b1100, 32'h08040201, 1'b0, 4'b0000, 8'h03, 1'b1, 16'd2};
    tbl[13] = '{1'b0, 4'b1100, 32'h08040201, 1'b0, 4'b0000, 8'h03, 1'b0, 16'd2};
    tbl[14] = '{1'b0, 4'b1100, 32'h08040201, 1'b0, 4'b0100, 8'h03, 1'b1, 16'd2};
    tbl[15] = '{1'b0, 4'b1000, 32'h08040201, 1'b0, 4'b0000, 8'h07, 1'b1, 16'd3};
    tbl[16] = '{1'b0, 4'b1000, 32'h08040201, 1'b0, 4'b0000, 8'h07, 1'b0, 16'd3};
    tbl[17] = '{1'b0, 4'b1000, 32'h08040201, 1'b0, 4'b1000, 8'h07, 1'b1, 16'd3};
    tbl[18] = '{1'b0, 4'b0000, 32'h08040201, 1'b0, 4'b0000, 8'h0F, 1'b1, 16'd4};
    tbl[19] = '{1'b0, 4'b0000, 32'h08040201, 1'b0, 4'b0000, 8'h0F, 1'b0, 16'd4};

    for (int i = 0; i < 20; i++) begin
      tick(tbl[i].rst, tbl[i].req, tbl[i].mask, tbl[i].clr);
      check("tbl_ack",  32'(ack),  32'(tbl[i].ack));
      check("tbl_q",    32'(q),    32'(tbl[i].q));
      check("tbl_busy", 32'(busy), 32'(tbl[i].busy));
      check("tbl_ops",  32'(ops),  32'(tbl[i].ops));
    end

    // Reset held two cycles while an op is in APPLY
    tick(1'b1, 4'b0000, 32'h0, 1'b0);
    tick(1'b0, 4'b0010, 32'h00005500, 1'b0);
    tick(1'b0, 4'b0000, 32'h00005500, 1'b0);
    tick(1'b0, 4'b0000, 32'h00005500, 1'b0);
    check("pre_rst_q", 32'(q), 32'h55);
    tick(1'b0, 4'b0100, 32'h00AA0000, 1'b0);
    check("pre_rst_ack", 32'(ack), 32'h4);
    tick(1'b1, 4'b0100, 32'h00AA0000, 1'b0);
    tick(1'b1, 4'b0000, 32'h00AA0000, 1'b0);
    check("rst_q",    32'(q),    32'h0);
    check("rst_ack",  32'(ack),  32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ops",  32'(ops),  32'h0);
    tick(1'b0, 4'b1111, 32'h0, 1'b0);
    check("rst_first_grant", 32'(ack), 32'h1);
    tick(1'b0, 4'b0000, 32'h0, 1'b0);
    tick(1'b0, 4'b0000, 32'h0, 1'b0);

    // Two requesters re-requesting continuously alternate
    tick(1'b1, 4'b0000, 32'h0, 1'b0);
    order[0] = 0; order[1] = 2; order[2] = 0; order[3] = 2;
    qexp[0] = 8'h80; qexp[1] = 8'h81; qexp[2] = 8'h01; qexp[3] = 8'h00;
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 4'b0101, 32'h00010080, 1'b0);
      check("rr_ack", 32'(ack), 32'(1 << order[k]));
      tick(1'b0, 4'b0101, 32'h00010080, 1'b0);
      check("rr_q", 32'(q), 32'(qexp[k]));
      tick(1'b0, 4'b0101, 32'h00010080, 1'b0);
    end

    // clr at the commit edge, then mask change during APPLY
    tick(1'b1, 4'b0000, 32'h0, 1'b0);
    tick(1'b0, 4'b0001, 32'h0000003C, 1'b0);
    tick(1'b0, 4'b0000, 32'h0000003C, 1'b0);
    tick(1'b0, 4'b0000, 32'h0000003C, 1'b0);
    check("clr_setup_q", 32'(q), 32'h3C);
    tick(1'b0, 4'b0010, 32'h0000FF00, 1'b0);
    check("clr_ack", 32'(ack), 32'h2);
    tick(1'b0, 4'b0000, 32'h0000FF00, 1'b1);
    check("clr_commit_q",   32'(q),   32'h0);
    check("clr_commit_ops", 32'(ops), 32'h2);
    tick(1'b0, 4'b0000, 32'h0, 1'b0);
    tick(1'b0, 4'b0001, 32'h0000003C, 1'b0);
    tick(1'b0, 4'b0000, 32'h0000003C, 1'b0);
    tick(1'b0, 4'b0000, 32'h0000003C, 1'b0);
    tick(1'b0, 4'b0010, 32'h0000FF00, 1'b0);
    tick(1'b0, 4'b0000, 32'h00000000, 1'b0);
    check("latched_mask_q", 32'(q), 32'hC3);
    tick(1'b0, 4'b0000, 32'h0, 1'b0);

    // Counter wrap with a zero-mask op
    force dut.ops_q = 16'hFFFF;
    m_ops = 16'hFFFF;
    tick(1'b0, 4'b0000, 32'h0, 1'b0);
    release dut.ops_q;
    tick(1'b0, 4'b0001, 32'h0, 1'b0);
    check("zero_mask_ack", 32'(ack), 32'h1);
    tick(1'b0, 4'b0000, 32'h0, 1'b0);
    check("wrap_ops",   32'(ops), 32'h0);
    check("zero_mask_q", 32'(q),  32'hC3);
    tick(1'b0, 4'b0000, 32'h0, 1'b0);

    // Random traffic against the reference
    for (int n = 0; n < 600; n++) begin
      r_req  = 4'($urandom_range(0, 15));
      r_mask = $urandom;
      r_rst  = ($urandom_range(0, 49) == 0);
      r_clr  = ($urandom_range(0, 9) == 0);
      tick(r_rst, r_req, r_mask, r_clr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
